// File: rtl/ex_muldiv_if.sv
// Execute-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        exe_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        result_valid;
    logic        div_by_zero;

    modport master (
        output start, op, src_a, src_b, flush,
        input  exe_stall, hi, lo, result_valid, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output exe_stall, hi, lo, result_valid, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO; stalls ID/EX while busy.
// Division is restoring, one quotient bit per cycle, on operand magnitudes.
module ex_muldiv #(
    parameter int MUL_CYCLES = 4
) (
    input  logic      clk,
    input  logic      resetn,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] cnt;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        result_valid_q;
    logic        dbz_q;

    logic        signed_op;
    logic        signed_in;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign signed_op = ~op_q[0];
    assign signed_in = ~bus.op[0];

    // Low 64 bits of a two's complement product are exact once both sides are sign-extended.
    assign ext_a   = {{32{signed_op & a_q[31]}}, a_q};
    assign ext_b   = {{32{signed_op & b_q[31]}}, b_q};
    assign product = ext_a * ext_b;

    assign a_mag_in = (signed_in && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign b_mag    = (signed_op && b_q[31]) ? (32'd0 - b_q) : b_q;

    assign rem_sh    = {rem, quot[31]};
    assign diff      = rem_sh - {1'b0, b_mag};
    assign rem_next  = diff[32] ? rem_sh[31:0] : diff[31:0];
    assign quot_next = {quot[30:0], ~diff[32]};

    // 0x80000000 / -1 negates back onto itself, giving the architectural wrap.
    assign quot_fix = (signed_op && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_next) : quot_next;
    assign rem_fix  = (signed_op && a_q[31]) ? (32'd0 - rem_next) : rem_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            op_q           <= 2'b00;
            a_q            <= 32'd0;
            b_q            <= 32'd0;
            cnt            <= 32'd0;
            quot           <= 32'd0;
            rem            <= 32'd0;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
            result_valid_q <= 1'b0;
            dbz_q          <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        op_q <= bus.op;
                        a_q  <= bus.src_a;
                        b_q  <= bus.src_b;
                        cnt  <= 32'd0;
                        rem  <= 32'd0;
                        quot <= a_mag_in;
                        if (!bus.op[1]) begin
                            state <= MUL;
                        end else if (bus.src_b != 32'd0) begin
                            state <= DIV;
                        end else begin
                            hi_q           <= bus.src_a;
                            lo_q           <= 32'hFFFF_FFFF;
                            dbz_q          <= 1'b1;
                            result_valid_q <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == 32'(MUL_CYCLES - 1)) begin
                        {hi_q, lo_q}   <= product;
                        result_valid_q <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        rem  <= rem_next;
                        quot <= quot_next;
                        cnt  <= cnt + 32'd1;
                        if (cnt == 32'd31) begin
                            lo_q           <= quot_fix;
                            hi_q           <= rem_fix;
                            dbz_q          <= 1'b0;
                            result_valid_q <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.exe_stall    = (state == MUL) || (state == DIV) ||
                              ((state == IDLE) && bus.start && !bus.flush);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.result_valid = result_valid_q;
    assign bus.div_by_zero  = dbz_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases then randomized operations,
// expected HI/LO computed with plain 64-bit arithmetic.
module tb_ex_muldiv;
    localparam int MC = 4;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk;
    logic resetn;
    ex_muldiv_if bus ();

    ex_muldiv #(.MUL_CYCLES(MC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    exp_t        sb_q[$];
    int          compared;
    int          mismatched;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Architectural definition of each op, independent of how the unit iterates.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic dbz_prev, output exp_t e);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = dbz_prev;
        case (op)
            2'b00: begin p = 64'(sa * sb); {e.hi, e.lo} = p; end
            2'b01: begin p = 64'(a) * 64'(b); {e.hi, e.lo} = p; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0]; e.dbz = 1'b0;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.dbz = 1'b0;
                end
            end
        endcase
    endfunction

    // mode 0: normal, mode 1: flush at cycle C0+k, mode 2: reset at cycle C0+k.
    // Entered and left just after a rising edge; leaves start high on normal completion.
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int mode, input int k);
        exp_t e;
        int   n;
        int   exp_n;
        bit   ended;
        ref_model(op, a, b, exp_dbz, e);
        exp_n = op[1] ? ((b == 32'd0) ? 1 : 33) : (MC + 1);
        if (mode == 0) begin
            sb_q.push_back(e);
            exp_hi = e.hi; exp_lo = e.lo; exp_dbz = e.dbz;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        n = 0;
        ended = 1'b0;
        for (int c = 0; c < 200 && !ended; c++) begin
            if (mode == 1 && c == k) begin
                bus.start = 1'b0;
                bus.flush = 1'b1;
            end
            if (mode == 2 && c == k) begin
                bus.start = 1'b0;
                resetn = 1'b0;
                #1;
                check_output("reset_mid_hi", bus.hi, 0);
                check_output("reset_mid_lo", bus.lo, 0);
                check_output("reset_mid_stall", bus.exe_stall, 0);
                check_output("reset_mid_dbz", bus.div_by_zero, 0);
                exp_hi = 32'd0; exp_lo = 32'd0; exp_dbz = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                return;
            end
            @(negedge clk);
            if (bus.exe_stall) n++;
            else ended = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            if (!ended) begin
                bus.src_a = $urandom;
                bus.src_b = $urandom;
                bus.op    = 2'($urandom_range(0, 3));
            end
        end
        if (!ended) check_output("stall_timeout", 1, 0);
        if (mode == 1) begin
            check_output("flush_stall_len", 64'(n), 64'(k + 1));
            check_output("flush_hi_held", bus.hi, exp_hi);
            check_output("flush_lo_held", bus.lo, exp_lo);
            check_output("flush_dbz_held", bus.div_by_zero, exp_dbz);
        end else begin
            check_output("stall_len", 64'(n), 64'(exp_n));
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && bus.result_valid) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_output("hi", bus.hi, e.hi);
                check_output("lo", bus.lo, e.lo);
                check_output("div_by_zero", bus.div_by_zero, e.dbz);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared = 0; mismatched = 0;
        exp_hi = 32'd0; exp_lo = 32'd0; exp_dbz = 1'b0;
        resetn = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
        bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_hi", bus.hi, 0);
        check_output("reset_lo", bus.lo, 0);
        check_output("reset_valid", bus.result_valid, 0);
        check_output("reset_dbz", bus.div_by_zero, 0);
        check_output("reset_stall", bus.exe_stall, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
        apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        apply_stimulus(2'b11, 32'd100, 32'd0, 0, 0);
        apply_stimulus(2'b01, 32'd2, 32'd3, 0, 0);
        bus.start = 1'b0;
        @(posedge clk); #1;

        apply_stimulus(2'b11, 32'h1234_5678, 32'h0000_0010, 1, 10);

        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01;
        @(negedge clk);
        check_output("idle_flush_stall", bus.exe_stall, 0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check_output("idle_flush_ignored", bus.exe_stall, 0);
        @(posedge clk); #1;

        apply_stimulus(2'b10, $urandom, $urandom | 32'd1, 2, 5);
        apply_stimulus(2'b01, 32'd7, 32'd6, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 2) == 0) begin
                bus.start = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            apply_stimulus(op, a, b, 0, 0);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("scoreboard_drained", 64'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes decoded rs/rt operand data and the mul/div op, and computes a 64-bit HI/LO result.
- Drives the exe_stall signal back to the ID/EX register, holding it while an operation is in flight.
- Presents the finished HI/LO for one handoff cycle so the pipeline can advance.

Parameters:
- MUL_CYCLES, 4, number of MUL-state cycles before the product is committed (>=1).

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  mul/div instruction present in EX; held high by upstream until the pipeline advances
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  32  rs operand (dividend / multiplicand)
- src_b  input  32  rt operand (divisor / multiplier)
- flush  input  1  abort the current operation (branch/exception squash)
- exe_stall  output  1  stall ID/EX and upstream stages
- hi  output  32  HI result (product upper / remainder)
- lo  output  32  LO result (product lower / quotient)
- result_valid  output  1  one-cycle pulse: hi/lo are new this cycle
- div_by_zero  output  1  last committed DIV/DIVU had src_b==0

Behaviour:
- Reset is asynchronous on resetn=0.
  - state=IDLE; hi=0, lo=0; result_valid=0; div_by_zero=0; internal counter, operands and partial remainder cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1:
  - Latch op, src_a, src_b; counter=0.
  - Go to MUL (op[1]=0), to DIV (op[1]=1 and src_b!=0), or straight to DONE for divide-by-zero.
- MUL:
  - Product is 64-bit: signed for MULT, unsigned for MULTU.
  - Counter increments each cycle. When counter==MUL_CYCLES-1: {hi,lo}<=product, go to DONE.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle, 32 cycles (counter 0..31).
  - On the last iteration, apply sign fixup and go to DONE:
    - DIV: quotient negated if sign(a)^sign(b); remainder takes sign(a).
    - DIVU: no fixup.
  - lo<=quotient, hi<=remainder, div_by_zero<=0.
  - 0x80000000 DIV 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
- Divide-by-zero (DIV/DIVU, src_b==0): hi<=src_a, lo<=0xFFFFFFFF, div_by_zero<=1; IDLE->DONE in one edge.
- DONE:
  - result_valid=1, exe_stall=0; start is ignored (same instruction still present).
  - Next state is always IDLE.
- exe_stall (combinational) = (state==MUL) | (state==DIV) | (state==IDLE & start & !flush).
- Latency, counted from the start cycle C0:
  - MUL: exe_stall high C0..C0+MUL_CYCLES; DONE at C0+MUL_CYCLES+1.
  - DIV: exe_stall high C0..C0+32; DONE at C0+33.
  - Divide-by-zero: stall in C0 only; DONE at C0+1.
- hi/lo change only on commit (or reset), and hold between operations.
- div_by_zero updates only on DIV/DIVU commits; it is held across MULT/MULTU.
- flush in MUL or DIV: next state IDLE; hi/lo/div_by_zero unchanged; no result_valid.
- flush in IDLE: start is ignored.
- flush in DONE: no effect (the result is already committed).
- src_a/src_b/op changes after the start cycle have no effect (operands are latched).
- Back-to-back: a new start is accepted in the IDLE cycle that follows DONE.
- resetn low mid-operation: immediate return to reset values; no result_valid.

Test Plan:
- MULT 0xFFFFFFFE (-2) x 0x00000003, MUL_CYCLES=4 -> stall 5 cycles; DONE at C0+5 with hi=0xFFFFFFFF, lo=0xFFFFFFFA, result_valid pulse of 1 cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed DIV cases:
  - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall exactly 33 cycles; DONE at C0+33.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> stall 1 cycle; next cycle hi=100, lo=0xFFFFFFFF, div_by_zero=1.
  - Follow with MULTU 2x3: div_by_zero stays 1, lo=6.
- DIVU 0x12345678 / 0x10 with flush at C0+10 -> exe_stall drops the next cycle; state IDLE; hi/lo keep previous values; no result_valid.
- resetn pulsed low at C0+5 of a DIV -> hi=lo=0, exe_stall=0 immediately.
  - A new MULTU 7x6 after reset release completes with lo=42.
